cnt_lap_sched: RTL and testbench

//  Job scheduler wrapped around the free-running 2-bit FSM counter (S0->S1->S2->[S3 if in]->S0).

---
 rtl/cnt_sched_pkg.sv | 17 +
 rtl/cnt_lap_sched_fsm_counter.sv | 37 +++
 rtl/cnt_lap_sched.sv | 153 +++++++++++++++
 tb/tb_cnt_lap_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_sched_pkg.sv
// rtl/cnt_sched_pkg.sv - shared counter state constants and scheduler state encoding
package cnt_sched_pkg;

    // Embedded 2-bit counter states
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;
    localparam logic [1:0] S3 = 2'd3;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        RUN   = 2'd2
    } sched_state_t;

endpackage

// File: rtl/cnt_lap_sched_fsm_counter.sv
// rtl/cnt_lap_sched_fsm_counter.sv - free-running 2-bit counter S0->S1->S2->[S3 if in]->S0
module fsm_counter
    import cnt_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       in,
    output logic [1:0] count
);

    logic [1:0] count_q;
    logic [1:0] count_d;

    // Next-state: S3 is only visited when 'in' is high while in S2
    always_comb begin
        count_d = S0;
        case (count_q)
            S0:      count_d = S1;
            S1:      count_d = S2;
            S2:      count_d = in ? S3 : S0;
            S3:      count_d = S0;
            default: count_d = S0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= S0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cnt_lap_sched.sv
// rtl/cnt_lap_sched.sv - lap job scheduler aligning jobs to the free-running counter
module cnt_lap_sched
    import cnt_sched_pkg::*;
#(
    parameter int LAP_W = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [LAP_W-1:0] cmd_laps,
    input  logic             cmd_abort,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [LAP_W-1:0] lap_cnt,
    output logic [1:0]       cnt_state
);

    sched_state_t     state_q, state_d;
    logic             pend_v_q, pend_v_d;
    logic             pend_mode_q, pend_mode_d;
    logic [LAP_W-1:0] pend_laps_q, pend_laps_d;
    logic             act_mode_q, act_mode_d;
    logic [LAP_W-1:0] act_laps_q, act_laps_d;
    logic [LAP_W-1:0] lap_cnt_q, lap_cnt_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic             cnt_in;
    logic             lap_end;
    logic             accept;
    logic             abort_eff;
    logic [LAP_W-1:0] lap_target;
    logic [LAP_W-1:0] lap_cnt_inc;
    logic             final_lap;

    fsm_counter u_counter (
        .clk   (clk),
        .rstn  (rstn),
        .in    (cnt_in),
        .count (cnt_state)
    );

    // The 4th state is only requested while a 4-state job is actually running
    assign cnt_in      = (state_q == RUN) & act_mode_q;
    // Counter is back at S0 on the next cycle
    assign lap_end     = (cnt_state == S3) | ((cnt_state == S2) & ~cnt_in);
    assign cmd_ready   = ~pend_v_q & ~cmd_abort;
    assign accept      = cmd_valid & cmd_ready;
    // Abort only matters when there is something to kill
    assign abort_eff   = cmd_abort & ((state_q != IDLE) | pend_v_q);
    // A request for zero laps runs a single lap
    assign lap_target  = (act_laps_q == '0) ? LAP_W'(1) : act_laps_q;
    assign lap_cnt_inc = lap_cnt_q + LAP_W'(1);
    assign final_lap   = lap_end & (lap_cnt_inc == lap_target);

    // Next-state, pending buffer and pulse generation
    always_comb begin
        state_d     = state_q;
        pend_v_d    = pend_v_q;
        pend_mode_d = pend_mode_q;
        pend_laps_d = pend_laps_q;
        act_mode_d  = act_mode_q;
        act_laps_d  = act_laps_q;
        // Final count stays visible alongside done, then clears
        lap_cnt_d   = done_q ? '0 : lap_cnt_q;
        done_d      = 1'b0;
        aborted_d   = 1'b0;

        // Accept only happens with the buffer empty, so it never collides with a promotion
        if (accept) begin
            pend_v_d    = 1'b1;
            pend_mode_d = cmd_mode;
            pend_laps_d = cmd_laps;
        end

        if (abort_eff) begin
            // Abort beats a same-cycle final lap; the counter just finishes its lap with in=0
            state_d   = IDLE;
            pend_v_d  = 1'b0;
            lap_cnt_d = '0;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pend_v_q) begin
                        act_mode_d = pend_mode_q;
                        act_laps_d = pend_laps_q;
                        pend_v_d   = 1'b0;
                        lap_cnt_d  = '0;
                        state_d    = ALIGN;
                    end
                end
                ALIGN: begin
                    // The S0 seen here is the first cycle of lap 1
                    if (cnt_state == S0) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (lap_end) begin
                        lap_cnt_d = lap_cnt_inc;
                        if (final_lap) begin
                            done_d = 1'b1;
                            if (pend_v_q) begin
                                // Back-to-back: next job's lap 1 begins in the coming S0
                                act_mode_d = pend_mode_q;
                                act_laps_d = pend_laps_q;
                                pend_v_d   = 1'b0;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Scheduler registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            pend_v_q    <= 1'b0;
            pend_mode_q <= 1'b0;
            pend_laps_q <= '0;
            act_mode_q  <= 1'b0;
            act_laps_q  <= '0;
            lap_cnt_q   <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_v_q    <= pend_v_d;
            pend_mode_q <= pend_mode_d;
            pend_laps_q <= pend_laps_d;
            act_mode_q  <= act_mode_d;
            act_laps_q  <= act_laps_d;
            lap_cnt_q   <= lap_cnt_d;
            done_q      <= done_d;
            aborted_q   <= aborted_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign aborted = aborted_q;
    assign lap_cnt = lap_cnt_q;

endmodule

// File: tb/tb_cnt_lap_sched.sv
// tb/tb_cnt_lap_sched.sv - directed vector bench for cnt_lap_sched
module tb_cnt_lap_sched;

    logic       clk;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_mode;
    logic [3:0] cmd_laps;
    logic       cmd_abort;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] lap_cnt;
    logic [1:0] cnt_state;

    int n_vec;
    int n_err;

    typedef struct {
        logic       v;
        logic       m;
        logic [3:0] l;
        logic       a;
        logic [1:0] e_cnt;
        logic       e_busy;
        logic       e_done;
        logic       e_ab;
        logic [3:0] e_lap;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[$];

    cnt_lap_sched #(.LAP_W(4)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_laps  (cmd_laps),
        .cmd_abort (cmd_abort),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .lap_cnt   (lap_cnt),
        .cnt_state (cnt_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic v, input logic m, input logic [3:0] l, input logic a,
                       input logic [1:0] c, input logic b, input logic d, input logic ab,
                       input logic [3:0] lc, input logic r);
        vec_t t;
        t.v = v; t.m = m; t.l = l; t.a = a;
        t.e_cnt = c; t.e_busy = b; t.e_done = d; t.e_ab = ab; t.e_lap = lc; t.e_rdy = r;
        tbl.push_back(t);
    endtask

    task automatic check_outs(input string nm, input int idx, input logic [1:0] c, input logic b,
                              input logic d, input logic ab, input logic [3:0] lc, input logic r);
        chk({nm, ".cnt_state"}, idx, int'(cnt_state), int'(c));
        chk({nm, ".busy"},      idx, int'(busy),      int'(b));
        chk({nm, ".done"},      idx, int'(done),      int'(d));
        chk({nm, ".aborted"},   idx, int'(aborted),   int'(ab));
        chk({nm, ".lap_cnt"},   idx, int'(lap_cnt),   int'(lc));
        chk({nm, ".cmd_ready"}, idx, int'(cmd_ready), int'(r));
    endtask

    // Wait (bounded) for an idle S1 cycle; leaves the bench at that cycle's negedge
    task automatic find_s1(input string nm, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (cnt_state == 2'd1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.find_s1: got timeout expected cnt_state=1", nm);
        end
    endtask

    // Submit one job at an idle S1 and observe the whole run
    task automatic run_job(input string nm, input logic m, input logic [3:0] l,
                           input int exp_off, input logic [3:0] exp_lap, input int exp_s3);
        logic       ok;
        int         off_done;
        int         dones;
        int         wraps;
        int         s3_seen;
        logic [3:0] lap_at;
        logic [3:0] maxl;
        logic [3:0] prev;
        off_done = -1; dones = 0; wraps = 0; s3_seen = 0;
        lap_at = '0; maxl = '0; prev = '0;
        find_s1(nm, ok);
        if (ok) begin
            cmd_valid = 1'b1; cmd_mode = m; cmd_laps = l;
            for (int k = 1; k <= 120; k++) begin
                @(negedge clk);
                cmd_valid = 1'b0;
                #1;
                if (cnt_state == 2'd3) s3_seen++;
                if (done) begin
                    dones++;
                    if (off_done < 0) begin
                        off_done = k;
                        lap_at   = lap_cnt;
                    end
                end
                if (lap_cnt > maxl) maxl = lap_cnt;
                if (off_done < 0 && prev != 4'd0 && lap_cnt == 4'd0) wraps++;
                prev = lap_cnt;
            end
            chk({nm, ".done_offset"}, 0, off_done, exp_off);
            chk({nm, ".done_count"},  0, dones, 1);
            chk({nm, ".lap_at_done"}, 0, int'(lap_at), int'(exp_lap));
            chk({nm, ".max_lap"},     0, int'(maxl), int'(exp_lap));
            chk({nm, ".wraps"},       0, wraps, 0);
            chk({nm, ".s3_cycles"},   0, s3_seen, exp_s3);
        end
    endtask

    initial begin
        logic ok;
        n_vec = 0;
        n_err = 0;
        rstn = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_laps = '0; cmd_abort = 1'b0;

        //  v  m  laps  a   cnt busy done ab lap rdy
        // Test 1: mode=1 laps=2 submitted at S1
        add(0, 0, 4'd0, 0,  0, 0, 0, 0, 0, 1);
        add(1, 1, 4'd2, 0,  1, 0, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  2, 0, 0, 0, 0, 0);
        add(0, 0, 4'd0, 0,  0, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  1, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  2, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  3, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  0, 1, 0, 0, 1, 1);
        add(0, 0, 4'd0, 0,  1, 1, 0, 0, 1, 1);
        add(0, 0, 4'd0, 0,  2, 1, 0, 0, 1, 1);
        add(0, 0, 4'd0, 0,  3, 1, 0, 0, 1, 1);
        add(0, 0, 4'd0, 0,  0, 0, 1, 0, 2, 1);
        // Test 2: mode=0 laps=3
        add(1, 0, 4'd3, 0,  1, 0, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  2, 0, 0, 0, 0, 0);
        add(0, 0, 4'd0, 0,  0, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  1, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  2, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  0, 1, 0, 0, 1, 1);
        add(0, 0, 4'd0, 0,  1, 1, 0, 0, 1, 1);
        add(0, 0, 4'd0, 0,  2, 1, 0, 0, 1, 1);
        add(0, 0, 4'd0, 0,  0, 1, 0, 0, 2, 1);
        add(0, 0, 4'd0, 0,  1, 1, 0, 0, 2, 1);
        add(0, 0, 4'd0, 0,  2, 1, 0, 0, 2, 1);
        add(0, 0, 4'd0, 0,  0, 0, 1, 0, 3, 1);
        // Test 3: A (mode=1 laps=1) then B (mode=0 laps=2) back to back
        add(1, 1, 4'd1, 0,  1, 0, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  2, 0, 0, 0, 0, 0);
        add(1, 0, 4'd2, 0,  0, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  1, 1, 0, 0, 0, 0);
        add(0, 0, 4'd0, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 4'd0, 0,  3, 1, 0, 0, 0, 0);
        add(0, 0, 4'd0, 0,  0, 1, 1, 0, 1, 1);
        add(0, 0, 4'd0, 0,  1, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  2, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  0, 1, 0, 0, 1, 1);
        add(0, 0, 4'd0, 0,  1, 1, 0, 0, 1, 1);
        add(0, 0, 4'd0, 0,  2, 1, 0, 0, 1, 1);
        add(0, 0, 4'd0, 0,  0, 0, 1, 0, 2, 1);
        // Test 4: mode=1 laps=3, pending job, abort in lap 2 with cmd_valid
        add(1, 1, 4'd3, 0,  1, 0, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  2, 0, 0, 0, 0, 0);
        add(0, 0, 4'd0, 0,  0, 1, 0, 0, 0, 1);
        add(1, 0, 4'd1, 0,  1, 1, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  2, 1, 0, 0, 0, 0);
        add(0, 0, 4'd0, 0,  3, 1, 0, 0, 0, 0);
        add(0, 0, 4'd0, 0,  0, 1, 0, 0, 1, 0);
        add(1, 1, 4'd5, 1,  1, 1, 0, 0, 1, 0);
        add(0, 0, 4'd0, 0,  2, 0, 0, 1, 0, 1);
        add(0, 0, 4'd0, 0,  0, 0, 0, 0, 0, 1);
        // Abort while idle with nothing pending: no pulse
        add(0, 0, 4'd0, 1,  1, 0, 0, 0, 0, 0);
        add(0, 0, 4'd0, 0,  2, 0, 0, 0, 0, 1);
        add(0, 0, 4'd0, 0,  0, 0, 0, 0, 0, 1);

        repeat (2) @(negedge clk);
        #1;
        check_outs("reset", 0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

        @(negedge clk);
        rstn = 1'b1;
        foreach (tbl[i]) begin
            cmd_valid = tbl[i].v;
            cmd_mode  = tbl[i].m;
            cmd_laps  = tbl[i].l;
            cmd_abort = tbl[i].a;
            #1;
            check_outs("vec", i, tbl[i].e_cnt, tbl[i].e_busy, tbl[i].e_done,
                       tbl[i].e_ab, tbl[i].e_lap, tbl[i].e_rdy);
            @(negedge clk);
        end
        cmd_valid = 1'b0; cmd_abort = 1'b0;

        // Test 5: zero laps runs one 4-state lap; 15 laps of 3 states never wrap
        run_job("laps0", 1'b1, 4'd0, 6, 4'd1, 1);
        run_job("laps15", 1'b0, 4'd15, 47, 4'd15, 0);

        // Test 6: async reset in RUN at S2 with a pending job
        find_s1("rst", ok);
        if (ok) begin
            cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_laps = 4'd3;
            @(negedge clk);
            cmd_valid = 1'b0;
            @(negedge clk);
            cmd_valid = 1'b1; cmd_mode = 1'b0; cmd_laps = 4'd2;
            @(negedge clk);
            cmd_valid = 1'b0;
            @(negedge clk);
            #1;
            check_outs("pre_rst", 0, 2'd2, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
            #1;
            rstn = 1'b0;
            #1;
            check_outs("in_rst", 0, 2'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
            @(negedge clk);
            rstn = 1'b1;
            for (int k = 0; k < 4; k++) begin
                #1;
                check_outs("post_rst", k, 2'(k % 3), 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
